// File: rtl/vector_line_engine.sv
// ============================================================================
//  vector_line_engine
//  Display-list vector renderer: walks polylines from a sync RAM on each
//  vblank rising edge and streams Bresenham pixels over valid/ready.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module vector_line_engine #(
  parameter int COORD_W = 8,
  parameter int DATA_W  = 8,
  parameter int LIST_AW = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               vblank,
  output logic [LIST_AW-1:0] list_addr,
  input  logic [DATA_W-1:0]  list_data,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [7:0]         pix_colour,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               busy,
  output logic               overrun
);

  localparam int EW = COORD_W + 2;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LEN   = 4'd1,
    S_ATTR  = 4'd2,
    S_SX    = 4'd3,
    S_SY    = 4'd4,
    S_PX    = 4'd5,
    S_PY    = 4'd6,
    S_SETUP = 4'd7,
    S_DRAW  = 4'd8
  } state_t;

  state_t               state_q, state_d;
  logic                 wait_q, wait_d;
  logic                 wrap_q, wrap_d;
  logic [LIST_AW-1:0]   addr_q, addr_d;
  logic                 vblank_last_q, vblank_last_d;
  logic                 overrun_q, overrun_d;
  logic                 abort_q, abort_d;
  logic [DATA_W-1:0]    n_q, n_d;
  logic [DATA_W-1:0]    seg_q, seg_d;
  logic [7:0]           attr_q, attr_d;
  logic [COORD_W-1:0]   x0_q, x0_d, y0_q, y0_d;
  logic [COORD_W-1:0]   x1_q, x1_d, y1_q, y1_d;
  logic [COORD_W-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic                 sxn_q, sxn_d, syn_q, syn_d;
  logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;

  logic                 start, term, restart, abort_req;
  logic [LIST_AW:0]     addr_inc;
  logic [COORD_W-1:0]   adx, ady;
  logic signed [EW:0]   e2, dx_ext, dy_ext;
  logic signed [EW-1:0] err_n;

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    wrap_d        = wrap_q;
    addr_d        = addr_q;
    vblank_last_d = vblank;
    overrun_d     = overrun_q;
    abort_d       = abort_q;
    n_d           = n_q;
    seg_d         = seg_q;
    attr_d        = attr_q;
    x0_d          = x0_q;
    y0_d          = y0_q;
    x1_d          = x1_q;
    y1_d          = y1_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    sxn_d         = sxn_q;
    syn_d         = syn_q;
    dx_d          = dx_q;
    dy_d          = dy_q;
    err_d         = err_q;

    start     = vblank & ~vblank_last_q;
    term      = 1'b0;
    restart   = 1'b0;
    abort_req = 1'b0;
    addr_inc  = {1'b0, addr_q} + {{LIST_AW{1'b0}}, 1'b1};
    adx       = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    ady       = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    e2        = $signed({err_q, 1'b0});
    dx_ext    = $signed({dx_q[EW-1], dx_q});
    dy_ext    = $signed({dy_q[EW-1], dy_q});
    err_n     = err_q;

    case (state_q)
      S_IDLE: begin
        if (start && enable) restart = 1'b1;
      end

      // First cycle presents the address, second cycle samples the RAM word.
      S_LEN, S_ATTR, S_SX, S_SY, S_PX, S_PY: begin
        if (!wait_q) begin
          if (wrap_q) term = 1'b1;
          else        wait_d = 1'b1;
        end else begin
          wait_d           = 1'b0;
          {wrap_d, addr_d} = addr_inc;
          case (state_q)
            S_LEN: begin
              if (list_data == '0) begin
                term = 1'b1;
              end else begin
                n_d     = list_data;
                seg_d   = '0;
                state_d = S_ATTR;
              end
            end
            S_ATTR: begin
              attr_d  = 8'(list_data);
              state_d = S_SX;
            end
            S_SX: begin
              x1_d    = COORD_W'(list_data);
              state_d = S_SY;
            end
            S_SY: begin
              y1_d    = COORD_W'(list_data);
              state_d = S_PX;
            end
            S_PX: begin
              x0_d    = x1_q;
              x1_d    = COORD_W'(list_data);
              state_d = S_PY;
            end
            S_PY: begin
              y0_d    = y1_q;
              y1_d    = COORD_W'(list_data);
              state_d = S_SETUP;
            end
            default: ;
          endcase
        end
      end

      S_SETUP: begin
        cur_x_d = x0_q;
        cur_y_d = y0_q;
        sxn_d   = ~(x1_q > x0_q);
        syn_d   = ~(y1_q > y0_q);
        dx_d    = $signed({2'b00, adx});
        dy_d    = -$signed({2'b00, ady});
        err_d   = $signed({2'b00, adx}) - $signed({2'b00, ady});
        state_d = S_DRAW;
      end

      S_DRAW: begin
        if (pix_ready) begin
          if (cur_x_q == x1_q && cur_y_q == y1_q) begin
            seg_d   = seg_q + DATA_W'(1);
            state_d = (seg_d == n_q) ? S_LEN : S_PX;
          end else begin
            // Both axis tests use the pre-step error term.
            if (e2 >= dy_ext) begin
              err_n   = err_n + dy_q;
              cur_x_d = sxn_q ? (cur_x_q - COORD_W'(1)) : (cur_x_q + COORD_W'(1));
            end
            if (e2 <= dx_ext) begin
              err_n   = err_n + dx_q;
              cur_y_d = syn_q ? (cur_y_q - COORD_W'(1)) : (cur_y_q + COORD_W'(1));
            end
            err_d = err_n;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (term) begin
      state_d   = S_IDLE;
      overrun_d = 1'b0;
      abort_d   = 1'b0;
    end

    // A start coinciding with list termination is simply a fresh pass.
    if (start && state_q != S_IDLE) begin
      if (term) begin
        if (enable) restart = 1'b1;
      end else begin
        abort_req = 1'b1;
        overrun_d = 1'b1;
      end
    end

    if (abort_q || abort_req) begin
      if (state_q != S_DRAW || pix_ready) begin
        abort_d = 1'b0;
        if (enable) restart = 1'b1;
        else        state_d = S_IDLE;
      end else begin
        abort_d = 1'b1;
      end
    end

    if (restart) begin
      state_d = S_LEN;
      addr_d  = '0;
      wait_d  = 1'b0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wait_q        <= 1'b0;
      wrap_q        <= 1'b0;
      addr_q        <= '0;
      vblank_last_q <= 1'b0;
      overrun_q     <= 1'b0;
      abort_q       <= 1'b0;
      n_q           <= '0;
      seg_q         <= '0;
      attr_q        <= '0;
      x0_q          <= '0;
      y0_q          <= '0;
      x1_q          <= '0;
      y1_q          <= '0;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      sxn_q         <= 1'b0;
      syn_q         <= 1'b0;
      dx_q          <= '0;
      dy_q          <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      wrap_q        <= wrap_d;
      addr_q        <= addr_d;
      vblank_last_q <= vblank_last_d;
      overrun_q     <= overrun_d;
      abort_q       <= abort_d;
      n_q           <= n_d;
      seg_q         <= seg_d;
      attr_q        <= attr_d;
      x0_q          <= x0_d;
      y0_q          <= y0_d;
      x1_q          <= x1_d;
      y1_q          <= y1_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      sxn_q         <= sxn_d;
      syn_q         <= syn_d;
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      err_q         <= err_d;
    end
  end

  assign list_addr  = addr_q;
  assign pix_x      = cur_x_q;
  assign pix_y      = cur_y_q;
  assign pix_colour = attr_q;
  assign pix_valid  = (state_q == S_DRAW);
  assign busy       = (state_q != S_IDLE);
  assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_vector_line_engine.sv
// ============================================================================
//  tb_vector_line_engine
//  Directed bench: hand-computed pixel sequences for vector_line_engine.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vector_line_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       vblank = 1'b0;
  logic       pix_ready = 1'b0;
  logic [8:0] list_addr;
  logic [7:0] list_data;
  logic [7:0] pix_x, pix_y, pix_colour;
  logic       pix_valid, busy, overrun;

  logic [7:0] mem [512];

  int tests = 0;
  int fails = 0;
  int bx[$];
  int by[$];
  int bc[$];

  vector_line_engine #(.COORD_W(8), .DATA_W(8), .LIST_AW(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .vblank     (vblank),
    .list_addr  (list_addr),
    .list_data  (list_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_colour (pix_colour),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) list_data <= mem[list_addr];

  task automatic set_list(input logic [7:0] w0, w1, w2, w3, w4, w5, w6, w7, w8);
    for (int k = 0; k < 512; k++) mem[k] = 8'd0;
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3; mem[4] = w4;
    mem[5] = w5; mem[6] = w6; mem[7] = w7; mem[8] = w8;
  endtask

  // mode 0: ready always 1; mode 1: ready toggles every cycle.
  // pulse2 >= 0 raises vblank again at that cycle index.
  task automatic run_pass(input int mode, input int pulse2, input int budget,
                          output int done, output int busy_cycles,
                          output int unstable, output int ovr_seen);
    logic       held;
    logic [7:0] hx, hy, hc;
    bx.delete(); by.delete(); bc.delete();
    done = 0; busy_cycles = 0; unstable = 0; ovr_seen = 0;
    held = 1'b0; hx = '0; hy = '0; hc = '0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (held && (!pix_valid || pix_x !== hx || pix_y !== hy || pix_colour !== hc))
        unstable++;
      vblank    = (i < 3) || (pulse2 >= 0 && i >= pulse2 && i < pulse2 + 3);
      pix_ready = (mode == 0) ? 1'b1 : 1'(i % 2);
      if (busy) busy_cycles++;
      if (overrun) ovr_seen = 1;
      held = 1'b0;
      if (pix_valid) begin
        if (pix_ready) begin
          bx.push_back(int'(pix_x)); by.push_back(int'(pix_y)); bc.push_back(int'(pix_colour));
        end else begin
          held = 1'b1; hx = pix_x; hy = pix_y; hc = pix_colour;
        end
      end
      if (i > 4 && !busy && !vblank) begin
        done = 1;
        break;
      end
    end
    vblank = 1'b0;
    pix_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    tests++;
    if ({pix_valid, busy, overrun} !== 3'b000 || list_addr !== 9'd0 ||
        pix_x !== 8'd0 || pix_y !== 8'd0 || pix_colour !== 8'd0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b busy=%b ovr=%b addr=%0d x=%0d y=%0d c=%h, expected all 0",
               pix_valid, busy, overrun, list_addr, pix_x, pix_y, pix_colour);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_horizontal();
    int done, bcyc, uns, ovs;
    int ex[4] = '{2, 3, 4, 5};
    set_list(8'd1, 8'h3F, 8'd2, 8'd5, 8'd5, 8'd5, 8'd0, 8'd0, 8'd0);
    run_pass(0, -1, 200, done, bcyc, uns, ovs);
    tests++;
    if (done != 1 || bx.size() != 4) begin
      fails++;
      $display("FAIL horiz_count: got done=%0d beats=%0d, expected done=1 beats=4", done, bx.size());
    end
    for (int j = 0; j < 4 && j < bx.size(); j++) begin
      tests++;
      if (bx[j] != ex[j] || by[j] != 5 || bc[j] != 'h3F) begin
        fails++;
        $display("FAIL horiz_beat[%0d]: got (%0d,%0d) c=%h, expected (%0d,5) c=3f", j, bx[j], by[j], bc[j], ex[j]);
      end
    end
    tests++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL horiz_idle: got busy=%b ovr=%b, expected 0 0", busy, overrun);
    end
  endtask

  task automatic test_steep();
    int done, bcyc, uns, ovs;
    int ex[5] = '{1, 1, 2, 2, 2};
    int ey[5] = '{0, 1, 2, 3, 4};
    set_list(8'd1, 8'hA1, 8'd1, 8'd0, 8'd2, 8'd4, 8'd0, 8'd0, 8'd0);
    run_pass(0, -1, 200, done, bcyc, uns, ovs);
    tests++;
    if (done != 1 || bx.size() != 5) begin
      fails++;
      $display("FAIL steep_count: got done=%0d beats=%0d, expected done=1 beats=5", done, bx.size());
    end
    for (int j = 0; j < 5 && j < bx.size(); j++) begin
      tests++;
      if (bx[j] != ex[j] || by[j] != ey[j] || bc[j] != 'hA1) begin
        fails++;
        $display("FAIL steep_beat[%0d]: got (%0d,%0d) c=%h, expected (%0d,%0d) c=a1", j, bx[j], by[j], bc[j], ex[j], ey[j]);
      end
    end
  endtask

  task automatic test_polyline();
    int done, bcyc, uns, ovs;
    int ex[8] = '{0, 1, 2, 3, 3, 3, 3, 3};
    int ey[8] = '{0, 1, 2, 3, 3, 2, 1, 0};
    set_list(8'd2, 8'h11, 8'd0, 8'd0, 8'd3, 8'd3, 8'd3, 8'd0, 8'd0);
    run_pass(0, -1, 300, done, bcyc, uns, ovs);
    tests++;
    if (done != 1 || bx.size() != 8) begin
      fails++;
      $display("FAIL poly_count: got done=%0d beats=%0d, expected done=1 beats=8", done, bx.size());
    end
    for (int j = 0; j < 8 && j < bx.size(); j++) begin
      tests++;
      if (bx[j] != ex[j] || by[j] != ey[j] || bc[j] != 'h11) begin
        fails++;
        $display("FAIL poly_beat[%0d]: got (%0d,%0d) c=%h, expected (%0d,%0d) c=11", j, bx[j], by[j], bc[j], ex[j], ey[j]);
      end
    end
  endtask

  task automatic test_backpressure();
    int done, bcyc, uns, ovs;
    set_list(8'd1, 8'h22, 8'd0, 8'd0, 8'd3, 8'd3, 8'd0, 8'd0, 8'd0);
    run_pass(1, -1, 300, done, bcyc, uns, ovs);
    tests++;
    if (done != 1 || bx.size() != 4 || uns != 0) begin
      fails++;
      $display("FAIL bp_stream: got done=%0d beats=%0d unstable=%0d, expected 1 4 0", done, bx.size(), uns);
    end
    for (int j = 0; j < 4 && j < bx.size(); j++) begin
      tests++;
      if (bx[j] != j || by[j] != j || bc[j] != 'h22) begin
        fails++;
        $display("FAIL bp_beat[%0d]: got (%0d,%0d) c=%h, expected (%0d,%0d) c=22", j, bx[j], by[j], bc[j], j, j);
      end
    end
  endtask

  task automatic test_overrun();
    int done, bcyc, uns, ovs, base, bad;
    set_list(8'd1, 8'h55, 8'd0, 8'd0, 8'd199, 8'd0, 8'd0, 8'd0, 8'd0);
    run_pass(0, 40, 1000, done, bcyc, uns, ovs);
    tests++;
    if (done != 1 || ovs != 1) begin
      fails++;
      $display("FAIL ovr_flag: got done=%0d overrun_seen=%0d, expected 1 1", done, ovs);
    end
    tests++;
    if (bx.size() <= 200 || bx.size() >= 400) begin
      fails++;
      $display("FAIL ovr_restart_count: got beats=%0d, expected between 201 and 399", bx.size());
    end
    bad = 0;
    base = bx.size() - 200;
    if (base >= 0) begin
      for (int j = 0; j < 200; j++)
        if (bx[base + j] != j || by[base + j] != 0) bad++;
    end
    tests++;
    if (base < 0 || bad != 0 || bx[0] != 0) begin
      fails++;
      $display("FAIL ovr_restart_seq: got bad=%0d base=%0d, expected restart from (0,0) with 200 clean beats", bad, base);
    end
    tests++;
    if (overrun !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ovr_clear: got overrun=%b busy=%b, expected 0 0", overrun, busy);
    end
  endtask

  task automatic test_empty();
    int done, bcyc, uns, ovs;
    set_list(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    run_pass(0, -1, 50, done, bcyc, uns, ovs);
    tests++;
    if (done != 1 || bx.size() != 0 || bcyc != 2) begin
      fails++;
      $display("FAIL empty_list: got done=%0d beats=%0d busy_cycles=%0d, expected 1 0 2", done, bx.size(), bcyc);
    end
    enable = 1'b0;
    set_list(8'd1, 8'h3F, 8'd2, 8'd5, 8'd5, 8'd5, 8'd0, 8'd0, 8'd0);
    run_pass(0, -1, 50, done, bcyc, uns, ovs);
    tests++;
    if (done != 1 || bx.size() != 0 || bcyc != 0) begin
      fails++;
      $display("FAIL disabled: got done=%0d beats=%0d busy_cycles=%0d, expected 1 0 0", done, bx.size(), bcyc);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_line();
    int done, bcyc, uns, ovs;
    set_list(8'd1, 8'h77, 8'd0, 8'd0, 8'd199, 8'd0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      vblank = (i < 3);
      pix_ready = 1'b1;
    end
    tests++;
    if (pix_valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_draw_active: got valid=%b busy=%b, expected 1 1", pix_valid, busy);
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({pix_valid, busy, overrun} !== 3'b000 || list_addr !== 9'd0 ||
        pix_x !== 8'd0 || pix_y !== 8'd0 || pix_colour !== 8'd0) begin
      fails++;
      $display("FAIL async_reset: got valid=%b busy=%b ovr=%b addr=%0d x=%0d y=%0d c=%h, expected all 0",
               pix_valid, busy, overrun, list_addr, pix_x, pix_y, pix_colour);
    end
    @(negedge clk); reset = 1'b0; pix_ready = 1'b0;
    set_list(8'd1, 8'h3F, 8'd2, 8'd5, 8'd5, 8'd5, 8'd0, 8'd0, 8'd0);
    run_pass(0, -1, 200, done, bcyc, uns, ovs);
    tests++;
    if (done != 1 || bx.size() != 4 || (bx.size() == 4 && (bx[0] != 2 || bx[3] != 5 || by[3] != 5))) begin
      fails++;
      $display("FAIL post_reset_pass: got done=%0d beats=%0d, expected 4 beats (2,5)..(5,5)", done, bx.size());
    end
  endtask

  initial begin
    for (int k = 0; k < 512; k++) mem[k] = 8'd0;
    #1;
    test_reset();
    test_horizontal();
    test_steep();
    test_polyline();
    test_backpressure();
    test_overrun();
    test_empty();
    test_reset_mid_line();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
